// File: rtl/aud_seq_pkg.sv
// rtl/aud_seq_pkg.sv - shared state encoding, defaults and frame type for the audio sequencer
package aud_seq_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RECORD = 2'b01,
        ST_PLAY   = 2'b10,
        ST_DELAY  = 2'b11
    } aud_state_t;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } aud_frame_t;

endpackage

// File: rtl/aud_mem_arb.sv
// rtl/aud_mem_arb.sv - write-priority arbiter for the single-port sample RAM
// A read that loses to a write waits in a one-entry pending slot; rd_done marks mem_rdata valid.
module aud_mem_arb
    import aud_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              AUD_BCLK,
    input  logic              NRST,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_pend,
    output logic              rd_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    logic [ADDR_W-1:0] pend_addr;

    always_ff @(posedge AUD_BCLK) begin
        if (!NRST) begin
            rd_pend   <= 1'b0;
            pend_addr <= '0;
            rd_done   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rd_done <= mem_en & ~mem_we;
            if (wr_req) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
                if (rd_req && !rd_pend) begin
                    rd_pend   <= 1'b1;
                    pend_addr <= rd_addr;
                end
            end else if (rd_pend) begin
                // a request arriving now is coalesced into the one being issued
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= pend_addr;
                rd_pend  <= 1'b0;
            end else if (rd_req) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= rd_addr;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aud_rec_play_ctrl.sv
// rtl/aud_rec_play_ctrl.sv - record/playback/live-delay sequencer feeding the DAC from sample RAM
// Optional AUD_MONITOR_EN: pass the live ADC frame to the DAC while recording.
module aud_rec_play_ctrl
    import aud_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              AUD_BCLK,
    input  logic              NRST,
    input  logic              cmd_rec,
    input  logic              cmd_play,
    input  logic              cmd_delay,
    input  logic              cmd_stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic              adc_vld,
    input  logic [DATA_W-1:0] adc_frame,
    input  logic              dac_req,
    output logic [DATA_W-1:0] dac_frame,
    output logic              dac_vld,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   rec_len,
    output logic              full
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    aud_state_t        st;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] dly;
    logic              wr_req;
    logic              rd_req;
    logic              rd_go;
    logic              last_rd;
    logic              rd_pend;
    logic              rd_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rec_frame;

    assign state = st;

    // D counts back from the newest frame, including one written in this same cycle
    always_comb begin
        wr_req  = adc_vld && !cmd_stop && (st == ST_RECORD || st == ST_DELAY);
        rd_req  = dac_req && !cmd_stop && (st == ST_PLAY || st == ST_DELAY);
        rd_go   = rd_req && !rd_pend;
        last_rd = ({1'b0, rd_ptr} == rec_len - (ADDR_W+1)'(1));
        rd_addr = rd_ptr;
        if (st == ST_DELAY)
            rd_addr = wr_ptr + ADDR_W'(wr_req) - ADDR_W'(1) - dly;
    end

`ifdef AUD_MONITOR_EN
    logic [DATA_W-1:0] mon_frame;

    always_ff @(posedge AUD_BCLK) begin
        if (!NRST)
            mon_frame <= '0;
        else if (st == ST_IDLE && cmd_rec && !cmd_stop)
            mon_frame <= '0;
        else if (wr_req && st == ST_RECORD)
            mon_frame <= adc_frame;
    end

    assign rec_frame = adc_vld ? adc_frame : mon_frame;
`else
    assign rec_frame = '0;
`endif

    always_ff @(posedge AUD_BCLK) begin
        if (!NRST) begin
            st        <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            dly       <= '0;
            rec_len   <= '0;
            full      <= 1'b0;
            dac_frame <= '0;
            dac_vld   <= 1'b0;
        end else begin
            dac_vld <= 1'b0;
            if (rd_done) begin
                dac_frame <= mem_rdata;
                dac_vld   <= 1'b1;
            end else if (dac_req && (st == ST_IDLE || st == ST_RECORD)) begin
                dac_frame <= (st == ST_RECORD) ? rec_frame : '0;
                dac_vld   <= 1'b1;
            end

            case (st)
                ST_IDLE: begin
                    if (cmd_stop) begin
                        st <= ST_IDLE;
                    end else if (cmd_rec) begin
                        st     <= ST_RECORD;
                        wr_ptr <= '0;
                        full   <= 1'b0;
                    end else if (cmd_play) begin
                        if (rec_len != '0) begin
                            st     <= ST_PLAY;
                            rd_ptr <= '0;
                        end
                    end else if (cmd_delay) begin
                        st     <= ST_DELAY;
                        wr_ptr <= '0;
                        dly    <= delay_len;
                    end
                end
                ST_RECORD: begin
                    if (cmd_stop) begin
                        rec_len <= {1'b0, wr_ptr};
                        st      <= ST_IDLE;
                    end else if (wr_req) begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                        if (wr_ptr == '1) begin
                            rec_len <= DEPTH;
                            full    <= 1'b1;
                            st      <= ST_IDLE;
                        end
                    end
                end
                ST_PLAY: begin
                    if (cmd_stop) begin
                        st <= ST_IDLE;
                    end else if (rd_go) begin
                        if (last_rd) begin
                            if (loop_en)
                                rd_ptr <= '0;
                            else
                                st <= ST_IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_W'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (cmd_stop)
                        st <= ST_IDLE;
                    else if (wr_req)
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    aud_mem_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_arb (
        .AUD_BCLK  (AUD_BCLK),
        .NRST      (NRST),
        .wr_req    (wr_req),
        .wr_addr   (wr_ptr),
        .wr_data   (adc_frame),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_pend   (rd_pend),
        .rd_done   (rd_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

endmodule

// File: tb/tb_aud_rec_play_ctrl.sv
// tb/tb_aud_rec_play_ctrl.sv - scoreboard bench for aud_rec_play_ctrl (16-bit and 4-bit address builds)
module tb_aud_rec_play_ctrl;

    logic        bclk = 1'b0;
    logic        nrst;
    logic        cmd_rec, cmd_play, cmd_delay, cmd_stop, loop_en;
    logic [15:0] delay_len;
    logic        adc_vld, dac_req;
    logic [31:0] adc_frame;

    logic [31:0] dac_frame_m, mem_wdata_m, rdata_m;
    logic        dac_vld_m, mem_en_m, mem_we_m, full_m;
    logic [15:0] mem_addr_m;
    logic [1:0]  state_m;
    logic [16:0] rec_len_m;

    logic [31:0] dac_frame_s, mem_wdata_s, rdata_s;
    logic        dac_vld_s, mem_en_s, mem_we_s, full_s;
    logic [3:0]  mem_addr_s;
    logic [1:0]  state_s;
    logic [4:0]  rec_len_s;

    logic [31:0] ram_m [0:65535];
    logic [31:0] ram_s [0:15];
    logic [31:0] sb [$];

    int errors = 0;
    int checks = 0;

    always #5 bclk = ~bclk;

    aud_rec_play_ctrl u_dut (
        .AUD_BCLK(bclk), .NRST(nrst), .cmd_rec(cmd_rec), .cmd_play(cmd_play),
        .cmd_delay(cmd_delay), .cmd_stop(cmd_stop), .loop_en(loop_en), .delay_len(delay_len),
        .adc_vld(adc_vld), .adc_frame(adc_frame), .dac_req(dac_req), .dac_frame(dac_frame_m),
        .dac_vld(dac_vld_m), .mem_en(mem_en_m), .mem_we(mem_we_m), .mem_addr(mem_addr_m),
        .mem_wdata(mem_wdata_m), .mem_rdata(rdata_m), .state(state_m), .rec_len(rec_len_m),
        .full(full_m)
    );

    aud_rec_play_ctrl #(.ADDR_W(4), .DATA_W(32)) u_small (
        .AUD_BCLK(bclk), .NRST(nrst), .cmd_rec(cmd_rec), .cmd_play(cmd_play),
        .cmd_delay(cmd_delay), .cmd_stop(cmd_stop), .loop_en(loop_en), .delay_len(delay_len[3:0]),
        .adc_vld(adc_vld), .adc_frame(adc_frame), .dac_req(dac_req), .dac_frame(dac_frame_s),
        .dac_vld(dac_vld_s), .mem_en(mem_en_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .mem_rdata(rdata_s), .state(state_s), .rec_len(rec_len_s),
        .full(full_s)
    );

    always @(posedge bclk) begin
        if (mem_en_m) begin
            if (mem_we_m) ram_m[mem_addr_m] <= mem_wdata_m;
            else          rdata_m <= ram_m[mem_addr_m];
        end
        if (mem_en_s) begin
            if (mem_we_s) ram_s[mem_addr_s] <= mem_wdata_s;
            else          rdata_s <= ram_s[mem_addr_s];
        end
    end

    // scoreboard: every dac_vld of the main instance must match the oldest expected frame
    always @(negedge bclk) begin
        if (dac_vld_m === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dac_vld frame=%h required=no dac_vld", dac_frame_m);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (dac_frame_m !== e) begin
                    errors++;
                    $display("FAIL dac_frame got=%h required=%h", dac_frame_m, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic adc_push(input logic [31:0] f);
        adc_frame = f;
        adc_vld   = 1'b1;
        tick();
        adc_vld   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic dac_request(input logic [31:0] exp, output int lat);
        lat     = -1;
        dac_req = 1'b1;
        sb.push_back(exp);
        tick();
        dac_req = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge bclk);
            if (dac_vld_m === 1'b1 && lat < 0) lat = n;
        end
    endtask

    task automatic apply_reset();
        nrst = 1'b0; cmd_rec = 0; cmd_play = 0; cmd_delay = 0; cmd_stop = 0;
        loop_en = 0; delay_len = '0; adc_vld = 0; dac_req = 0; adc_frame = '0;
        repeat (2) tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({state_m, rec_len_m, full_m, dac_frame_m, dac_vld_m, mem_en_m, mem_we_m} !== '0) begin
            errors++;
            $display("FAIL reset_main state=%0d rec_len=%0d full=%b dac_vld=%b mem_en=%b required=all 0",
                     state_m, rec_len_m, full_m, dac_vld_m, mem_en_m);
        end
        checks++;
        if ({state_s, rec_len_s, full_s, mem_en_s} !== '0) begin
            errors++;
            $display("FAIL reset_small state=%0d rec_len=%0d required=0", state_s, rec_len_s);
        end
    endtask

    task automatic test_record();
        cmd_rec = 1; tick(); cmd_rec = 0;
        checks++;
        if (state_m !== 2'b01) begin errors++; $display("FAIL rec_state got=%0d required=1", state_m); end
        for (int i = 1; i <= 8; i++) adc_push(32'h0001_0001 * i);
        cmd_stop = 1; tick(); cmd_stop = 0;
        checks++;
        if (rec_len_m !== 17'd8 || state_m !== 2'b00) begin
            errors++;
            $display("FAIL rec_stop rec_len=%0d state=%0d required=8,0", rec_len_m, state_m);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ram_m[i] !== 32'h0001_0001 * (i + 1)) begin
                errors++;
                $display("FAIL rec_ram[%0d] got=%h required=%h", i, ram_m[i], 32'h0001_0001 * (i + 1));
            end
        end
    endtask

    task automatic test_play_once();
        int lat;
        loop_en = 0;
        cmd_play = 1; tick(); cmd_play = 0;
        checks++;
        if (state_m !== 2'b10) begin errors++; $display("FAIL play_state got=%0d required=2", state_m); end
        for (int i = 1; i <= 8; i++) begin
            dac_request(32'h0001_0001 * i, lat);
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL play_latency[%0d] got=%0d required=2", i, lat); end
        end
        checks++;
        if (state_m !== 2'b00) begin errors++; $display("FAIL play_end_state got=%0d required=0", state_m); end
        dac_request(32'h0, lat);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL idle_latency got=%0d required=0", lat); end
    endtask

    task automatic test_play_loop();
        int lat;
        loop_en = 1;
        cmd_play = 1; tick(); cmd_play = 0;
        for (int i = 0; i < 10; i++) begin
            dac_request(32'h0001_0001 * ((i % 8) + 1), lat);
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL loop_latency[%0d] got=%0d required=2", i, lat); end
        end
        checks++;
        if (state_m !== 2'b10) begin errors++; $display("FAIL loop_state got=%0d required=2", state_m); end
        cmd_stop = 1; tick(); cmd_stop = 0;
        loop_en = 0;
    endtask

    task automatic test_full();
        apply_reset();
        cmd_rec = 1; tick(); cmd_rec = 0;
        for (int i = 1; i <= 20; i++) begin
            adc_push(32'h0100_0000 + i);
            if (i == 15) begin
                checks++;
                if (state_s !== 2'b01 || full_s !== 1'b0) begin
                    errors++;
                    $display("FAIL full_early state=%0d full=%b required=1,0", state_s, full_s);
                end
            end
            if (i == 16) begin
                checks++;
                if (state_s !== 2'b00 || full_s !== 1'b1 || rec_len_s !== 5'd16) begin
                    errors++;
                    $display("FAIL full_set state=%0d full=%b rec_len=%0d required=0,1,16",
                             state_s, full_s, rec_len_s);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram_s[i] !== 32'h0100_0000 + i + 1) begin
                errors++;
                $display("FAIL full_ignored[%0d] got=%h required=%h", i, ram_s[i], 32'h0100_0000 + i + 1);
            end
        end
        cmd_stop = 1; tick(); cmd_stop = 0;
        cmd_rec = 1; tick(); cmd_rec = 0;
        checks++;
        if (full_s !== 1'b0) begin errors++; $display("FAIL full_clear got=%b required=0", full_s); end
        cmd_stop = 1; tick(); cmd_stop = 0;
    endtask

    task automatic test_delay();
        int lat;
        apply_reset();
        delay_len = 16'd3;
        cmd_delay = 1; tick(); cmd_delay = 0;
        for (int k = 0; k < 6; k++) adc_push(32'hA000_0000 + k);
        adc_frame = 32'hA000_0006;
        adc_vld = 1; dac_req = 1;
        sb.push_back(32'hA000_0003);
        tick();
        adc_vld = 0; dac_req = 0;
        checks++;
        if (mem_en_m !== 1'b1 || mem_we_m !== 1'b1 || mem_addr_m !== 16'd6) begin
            errors++;
            $display("FAIL collide_write en=%b we=%b addr=%0d required=1,1,6", mem_en_m, mem_we_m, mem_addr_m);
        end
        tick();
        checks++;
        if (mem_en_m !== 1'b1 || mem_we_m !== 1'b0 || mem_addr_m !== 16'd3) begin
            errors++;
            $display("FAIL collide_read en=%b we=%b addr=%0d required=1,0,3", mem_en_m, mem_we_m, mem_addr_m);
        end
        tick();
        checks++;
        if (dac_vld_m !== 1'b0) begin errors++; $display("FAIL collide_early_vld got=%b required=0", dac_vld_m); end
        tick();
        checks++;
        if (dac_vld_m !== 1'b1) begin errors++; $display("FAIL collide_vld got=%b required=1", dac_vld_m); end
        repeat (2) tick();
        adc_push(32'hA000_0007);
        dac_request(32'hA000_0004, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL delay_latency got=%0d required=2", lat); end
        cmd_stop = 1; tick(); cmd_stop = 0;
        delay_len = 16'd0;
        cmd_delay = 1; tick(); cmd_delay = 0;
        adc_push(32'hB000_0001);
        dac_request(32'hB000_0001, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL delay0_latency got=%0d required=2", lat); end
        cmd_stop = 1; tick(); cmd_stop = 0;
    endtask

    task automatic test_stop_and_reset();
        cmd_play = 1; tick(); cmd_play = 0;
        checks++;
        if (state_m !== 2'b00) begin errors++; $display("FAIL play_empty state=%0d required=0", state_m); end
        cmd_rec = 1; tick(); cmd_rec = 0;
        adc_push(32'hC000_0001);
        adc_push(32'hC000_0002);
        cmd_stop = 1; tick(); cmd_stop = 0;
        loop_en = 1;
        cmd_play = 1; tick(); cmd_play = 0;
        cmd_stop = 1; cmd_rec = 1; tick(); cmd_stop = 0; cmd_rec = 0;
        checks++;
        if (state_m !== 2'b00 || rec_len_m !== 17'd2) begin
            errors++;
            $display("FAIL stop_rec state=%0d rec_len=%0d required=0,2", state_m, rec_len_m);
        end
        cmd_play = 1; tick(); cmd_play = 0;
        dac_req = 1; tick(); dac_req = 0;
        checks++;
        if (mem_en_m !== 1'b1 || mem_we_m !== 1'b0) begin
            errors++;
            $display("FAIL midread_strobe en=%b we=%b required=1,0", mem_en_m, mem_we_m);
        end
        nrst = 0;
        tick();
        for (int n = 0; n < 2; n++) begin
            checks++;
            if ({state_m, rec_len_m, full_m, dac_frame_m, dac_vld_m, mem_en_m, mem_we_m,
                 mem_addr_m, mem_wdata_m} !== '0) begin
                errors++;
                $display("FAIL midread_reset[%0d] state=%0d dac_vld=%b mem_en=%b dac_frame=%h required=all 0",
                         n, state_m, dac_vld_m, mem_en_m, dac_frame_m);
            end
            tick();
        end
        nrst = 1;
        repeat (4) tick();
        loop_en = 0;
    endtask

    initial begin
        test_reset();
        test_record();
        test_play_once();
        test_play_loop();
        test_full();
        test_delay();
        test_stop_and_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
